morse_key_decoder: RTL and testbench
====================================

MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 SHALL have parameter MAX_SYMBOLS, default 5, meaning the maximum number of symbols per character; legal range 5..8.
REQ-002 SHALL have parameter MIN_TICKS, default 2, meaning marks shorter than this many cycles are glitches.
REQ-003 SHALL have parameter DASH_TICKS, default 6, meaning marks of at least this many cycles are dashes.
REQ-004 SHALL have parameter LETTER_GAP_TICKS, default 10, meaning this much silence ends a character.
REQ-005 SHALL have parameter WORD_GAP_TICKS, default 24, meaning this much silence ends a word.
REQ-006 SHALL have parameter CNT_W, default 16, meaning the width of the mark and gap counters.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port key, input, 1 bit: synchronised, debounced key; 1 = pressed.
REQ-010 SHALL have port ascii_char, output, 8 bits: last emitted character, held between emissions.
REQ-011 SHALL have port char_valid, output, 1 bit: one-cycle pulse when ascii_char is updated.
REQ-012 SHALL have port decode_err, output, 1 bit: one-cycle pulse, coincident with char_valid, when the emitted code is unmapped or overflowed.
REQ-013 SHALL have port sym_count, output, 4 bits: symbols accepted in the current character.
REQ-014 SHALL have port busy, output, 1 bit: 1 whenever state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, MARK, GAP, EMIT, WORD_WAIT and EMIT_SPACE.
REQ-016 SHALL, in IDLE with key=1, go to MARK with mark_cnt=1.
REQ-017 SHALL, in MARK with key=1, increment mark_cnt, saturating at all-ones.
REQ-018 SHALL, in MARK when key=0 is sampled with mark_cnt<MIN_TICKS, discard the mark without changing the symbol buffer, then go to GAP (if sym_count>0, gap_cnt continuing from its pre-mark value) or to IDLE (if sym_count=0).
REQ-019 SHALL, in MARK when key=0 is sampled with mark_cnt>=MIN_TICKS, append dot (mark_cnt<DASH_TICKS) or dash (otherwise), then go to GAP with gap_cnt=1.
REQ-020 SHALL buffer symbols in first-symbol-first order (dot=0, dash=1) in a MAX_SYMBOLS-bit shift register with the count held in sym_count.
REQ-021 SHALL, when a symbol is appended while sym_count=MAX_SYMBOLS, leave the buffer unchanged and set a sticky overflow flag.
REQ-022 SHALL, in GAP with key=1, go to MARK with mark_cnt=1.
REQ-023 SHALL, in GAP with key=0, increment gap_cnt and go to EMIT on the cycle gap_cnt reaches LETTER_GAP_TICKS.
REQ-024 SHALL, in EMIT (exactly one cycle), register ascii_char from the lookup, pulse char_valid, clear the buffer, sym_count and overflow, and go to WORD_WAIT, with gap_cnt continuing.
REQ-025 SHALL, in WORD_WAIT with key=1, go to MARK with mark_cnt=1 and emit no space.
REQ-026 SHALL, in WORD_WAIT, go to EMIT_SPACE when gap_cnt reaches WORD_GAP_TICKS.
REQ-027 SHALL, in EMIT_SPACE, output ascii_char=" " (8'h20), pulse char_valid with decode_err=0, and go to IDLE.
REQ-028 SHALL, when key=1 is sampled in EMIT or EMIT_SPACE, complete the emission and then go to MARK with mark_cnt=1.
REQ-029 SHALL decode using the standard ITU table: A–Z, 0–9, all codes of at most 5 symbols.
REQ-030 SHALL emit "?" (8'h3F) with decode_err=1 for any unmapped code, any code longer than 5 symbols, or any set overflow flag.
REQ-031 SHALL register the latency as follows: if key=0 is first sampled at edge N and stays low, char_valid is high in the cycle after edge N+LETTER_GAP_TICKS.
REQ-032 SHALL never assert char_valid in two consecutive cycles.
REQ-033 SHALL leave counters saturated and never wrapping.
REQ-034 SHALL require, as a legal parameter precondition, MIN_TICKS<DASH_TICKS<LETTER_GAP_TICKS<WORD_GAP_TICKS<2^CNT_W.

Reset
REQ-035 SHALL, on reset=1 (asynchronous, any state including mid-MARK), immediately set state=IDLE, ascii_char="-" (8'h2D), char_valid=0, decode_err=0, sym_count=0, busy=0, clear all counters, the buffer and overflow.
REQ-036 SHALL, after reset release, start the first mark only on key=1 sampled at a rising edge.

Verification
REQ-037 SHALL cover: key held 3 cycles, low 3 cycles, held 8 cycles, then low -> "A" (8'h41), char_valid for 1 cycle, decode_err=0.
REQ-038 SHALL cover: key held 1 cycle between valid dots of "..." -> "S" emitted, glitch ignored, sym_count peaks at 3.
REQ-039 SHALL cover: dashes "-----" then silence of 30 cycles -> "0" then " ", two char_valid pulses separated by 14 cycles, then busy=0.
REQ-040 SHALL cover: dots "......" (6 dots, MAX_SYMBOLS=5) -> "?", decode_err=1, sym_count capped at 5.
REQ-041 SHALL cover: "..-." (unmapped at 4 symbols? no: F) then "..--" -> "F" then "?" with decode_err=1.
REQ-042 SHALL cover: reset asserted mid-MARK on the 4th cycle -> outputs at reset values in the same cycle; the next "-" yields "T".

Source files
------------

// File: rtl/morse_key_decoder.sv
// ============================================================================
// Module  : morse_key_decoder
// Brief   : Times key marks/gaps, buffers dots and dashes, emits ITU ASCII.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_key_decoder #(
  parameter int MAX_SYMBOLS      = 5,
  parameter int MIN_TICKS        = 2,
  parameter int DASH_TICKS       = 6,
  parameter int LETTER_GAP_TICKS = 10,
  parameter int WORD_GAP_TICKS   = 24,
  parameter int CNT_W            = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  output logic       decode_err,
  output logic [3:0] sym_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MARK       = 3'd1,
    S_GAP        = 3'd2,
    S_EMIT       = 3'd3,
    S_WORD_WAIT  = 3'd4,
    S_EMIT_SPACE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] C_MIN_TICKS  = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] C_DASH_TICKS = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] C_LETTER_GAP = CNT_W'(LETTER_GAP_TICKS);
  localparam logic [CNT_W-1:0] C_WORD_GAP   = CNT_W'(WORD_GAP_TICKS);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [3:0]       C_SYM_MAX    = 4'(MAX_SYMBOLS);
  localparam logic [7:0]       C_CHAR_ERR   = 8'h3F;
  localparam logic [7:0]       C_CHAR_SPACE = 8'h20;
  localparam logic [7:0]       C_CHAR_RESET = 8'h2D;

  state_t                 r_state,    w_state_nxt;
  logic [CNT_W-1:0]       r_mark_cnt, w_mark_cnt_nxt;
  logic [CNT_W-1:0]       r_gap_cnt,  w_gap_cnt_nxt;
  logic [MAX_SYMBOLS-1:0] r_sym_buf,  w_sym_buf_nxt;
  logic [3:0]             r_sym_cnt,  w_sym_cnt_nxt;
  logic                   r_ovf,      w_ovf_nxt;
  logic [7:0]             r_ascii,    w_ascii_nxt;
  logic                   r_valid,    w_valid_nxt;
  logic                   r_err,      w_err_nxt;
  logic [CNT_W-1:0]       w_mark_inc, w_gap_inc;
  logic [8:0]             w_lookup;

  // Code key is {length, pattern}; the first symbol sits in the MSB of the
  // used length and unused upper pattern bits are always zero.
  function automatic logic [8:0] f_lookup(input logic [3:0] len, input logic [4:0] pat);
    logic [7:0] c;
    c = C_CHAR_ERR;
    if (len <= 4'd5) begin
      case ({len[2:0], pat})
        {3'd1, 5'b00000}: c = "E";  {3'd1, 5'b00001}: c = "T";
        {3'd2, 5'b00000}: c = "I";  {3'd2, 5'b00001}: c = "A";
        {3'd2, 5'b00010}: c = "N";  {3'd2, 5'b00011}: c = "M";
        {3'd3, 5'b00000}: c = "S";  {3'd3, 5'b00001}: c = "U";
        {3'd3, 5'b00010}: c = "R";  {3'd3, 5'b00011}: c = "W";
        {3'd3, 5'b00100}: c = "D";  {3'd3, 5'b00101}: c = "K";
        {3'd3, 5'b00110}: c = "G";  {3'd3, 5'b00111}: c = "O";
        {3'd4, 5'b00000}: c = "H";  {3'd4, 5'b00001}: c = "V";
        {3'd4, 5'b00010}: c = "F";  {3'd4, 5'b00100}: c = "L";
        {3'd4, 5'b00110}: c = "P";  {3'd4, 5'b00111}: c = "J";
        {3'd4, 5'b01000}: c = "B";  {3'd4, 5'b01001}: c = "X";
        {3'd4, 5'b01010}: c = "C";  {3'd4, 5'b01011}: c = "Y";
        {3'd4, 5'b01100}: c = "Z";  {3'd4, 5'b01101}: c = "Q";
        {3'd5, 5'b00000}: c = "5";  {3'd5, 5'b00001}: c = "4";
        {3'd5, 5'b00011}: c = "3";  {3'd5, 5'b00111}: c = "2";
        {3'd5, 5'b01111}: c = "1";  {3'd5, 5'b10000}: c = "6";
        {3'd5, 5'b11000}: c = "7";  {3'd5, 5'b11100}: c = "8";
        {3'd5, 5'b11110}: c = "9";  {3'd5, 5'b11111}: c = "0";
        default:          c = C_CHAR_ERR;
      endcase
    end
    return {(c == C_CHAR_ERR), c};
  endfunction

  assign w_mark_inc = (r_mark_cnt == C_CNT_MAX) ? r_mark_cnt : r_mark_cnt + 1'b1;
  assign w_gap_inc  = (r_gap_cnt  == C_CNT_MAX) ? r_gap_cnt  : r_gap_cnt  + 1'b1;
  assign w_lookup   = f_lookup(r_sym_cnt, r_sym_buf[4:0]);

  always_comb begin
    w_state_nxt    = r_state;
    w_mark_cnt_nxt = r_mark_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_sym_buf_nxt  = r_sym_buf;
    w_sym_cnt_nxt  = r_sym_cnt;
    w_ovf_nxt      = r_ovf;
    w_ascii_nxt    = r_ascii;
    w_valid_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gap_cnt_nxt = '0;
        if (key) begin
          w_state_nxt    = S_MARK;
          w_mark_cnt_nxt = CNT_W'(1);
        end
      end
      S_MARK: begin
        if (key) begin
          w_mark_cnt_nxt = w_mark_inc;
        end else if (r_mark_cnt < C_MIN_TICKS) begin
          // Glitch: gap timing resumes as if the mark never happened.
          w_state_nxt = (r_sym_cnt != 4'd0) ? S_GAP : S_IDLE;
        end else begin
          w_state_nxt   = S_GAP;
          w_gap_cnt_nxt = CNT_W'(1);
          if (r_sym_cnt == C_SYM_MAX) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_sym_buf_nxt = {r_sym_buf[MAX_SYMBOLS-2:0], (r_mark_cnt >= C_DASH_TICKS)};
            w_sym_cnt_nxt = r_sym_cnt + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (key) begin
          w_state_nxt    = S_MARK;
          w_mark_cnt_nxt = CNT_W'(1);
        end else begin
          w_gap_cnt_nxt = w_gap_inc;
          if (w_gap_inc >= C_LETTER_GAP) w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        w_ascii_nxt   = r_ovf ? C_CHAR_ERR : w_lookup[7:0];
        w_err_nxt     = r_ovf | w_lookup[8];
        w_valid_nxt   = 1'b1;
        w_sym_buf_nxt = '0;
        w_sym_cnt_nxt = 4'd0;
        w_ovf_nxt     = 1'b0;
        w_gap_cnt_nxt = w_gap_inc;
        if (key) begin
          w_state_nxt    = S_MARK;
          w_mark_cnt_nxt = CNT_W'(1);
        end else begin
          w_state_nxt = S_WORD_WAIT;
        end
      end
      S_WORD_WAIT: begin
        if (key) begin
          w_state_nxt    = S_MARK;
          w_mark_cnt_nxt = CNT_W'(1);
        end else begin
          w_gap_cnt_nxt = w_gap_inc;
          if (w_gap_inc >= C_WORD_GAP) w_state_nxt = S_EMIT_SPACE;
        end
      end
      S_EMIT_SPACE: begin
        w_ascii_nxt   = C_CHAR_SPACE;
        w_valid_nxt   = 1'b1;
        w_gap_cnt_nxt = '0;
        if (key) begin
          w_state_nxt    = S_MARK;
          w_mark_cnt_nxt = CNT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mark_cnt <= '0;
      r_gap_cnt  <= '0;
      r_sym_buf  <= '0;
      r_sym_cnt  <= 4'd0;
      r_ovf      <= 1'b0;
      r_ascii    <= C_CHAR_RESET;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mark_cnt <= w_mark_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_sym_buf  <= w_sym_buf_nxt;
      r_sym_cnt  <= w_sym_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_ascii    <= w_ascii_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign ascii_char = r_ascii;
  assign char_valid = r_valid;
  assign decode_err = r_err;
  assign sym_count  = r_sym_cnt;
  assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_morse_key_decoder.sv
// ============================================================================
// Module  : tb_morse_key_decoder
// Brief   : Directed key timing with a queued scoreboard of expected chars.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_key_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic [7:0] ascii_char;
  logic       char_valid;
  logic       decode_err;
  logic [3:0] sym_count;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [8:0] exp_q[$];
  int         last_cyc = 0;
  int         prev_cyc = 0;
  int         peak = 0;
  int         last_peak = 0;
  logic       prev_v = 1'b0;

  morse_key_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .ascii_char (ascii_char),
    .char_valid (char_valid),
    .decode_err (decode_err),
    .sym_count  (sym_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every char_valid pulse pops one expected {err, char}.
  always @(negedge clk) begin
    logic [8:0] e;
    if (int'(sym_count) > peak) peak = int'(sym_count);
    if (char_valid) begin
      tests++;
      if (prev_v) begin
        fails++;
        $display("FAIL back_to_back_valid: got valid in consecutive cycles at cycle %0d, required gap", cyc);
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_char: got err=%0b char=%h, required no emission", decode_err, ascii_char);
      end else begin
        e = exp_q.pop_front();
        if ({decode_err, ascii_char} !== e) begin
          fails++;
          $display("FAIL char_out: got err=%0b char=%h, required err=%0b char=%h",
                   decode_err, ascii_char, e[8], e[7:0]);
        end
      end
      prev_cyc  = last_cyc;
      last_cyc  = cyc;
      last_peak = peak;
      peak      = 0;
    end
    prev_v = char_valid;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark(input int n);
    key = 1'b1;
    repeat (n) tick();
    key = 1'b0;
  endtask

  task automatic gap(input int n);
    key = 1'b0;
    repeat (n) tick();
  endtask

  // '.' is a 3-cycle mark, '-' an 8-cycle mark; 3-cycle intra gaps, tail after last.
  task automatic send(input string pat, input int tail);
    for (int i = 0; i < pat.len(); i++) begin
      mark((pat[i] == "-") ? 8 : 3);
      gap((i == pat.len() - 1) ? tail : 3);
    end
  endtask

  task automatic push(input logic err, input logic [7:0] c);
    exp_q.push_back({err, c});
  endtask

  initial begin
    int rel;
    key   = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_ascii", int'(ascii_char), 8'h2D);
    check("rst_valid", int'(char_valid), 0);
    check("rst_err",   int'(decode_err), 0);
    check("rst_sym",   int'(sym_count),  0);
    check("rst_busy",  int'(busy),       0);
    reset = 1'b0;
    gap(3);
    check("idle_busy", int'(busy), 0);

    // "A" with emission latency measured from the first low sample.
    push(1'b0, 8'h41);
    mark(3); gap(3); mark(8);
    rel = cyc;
    gap(15);
    check("A_latency", last_cyc, rel + 11);

    // "S" with a 1-cycle glitch between dots; no space since key returns early.
    push(1'b0, 8'h53);
    mark(3); gap(3); mark(1); gap(3); mark(3); gap(3); mark(3); gap(15);
    check("S_peak_sym", last_peak, 3);

    // "0" then a word space 14 cycles later, then idle.
    push(1'b0, 8'h30);
    push(1'b0, 8'h20);
    send("-----", 30);
    check("space_spacing", last_cyc - prev_cyc, 14);
    check("after_space_busy", int'(busy), 0);

    // Six dots overflow a five-symbol buffer.
    push(1'b1, 8'h3F);
    send("......", 15);
    check("ovf_peak_sym", last_peak, 5);

    // "F" then the unmapped "..--" followed by a space.
    push(1'b0, 8'h46);
    send("..-.", 15);
    push(1'b1, 8'h3F);
    push(1'b0, 8'h20);
    send("..--", 30);
    check("idle_after_err", int'(busy), 0);

    // Reset during the 4th cycle of a mark in the middle of a character.
    mark(3); gap(3);
    key = 1'b1;
    repeat (3) tick();
    check("pre_rst_sym", int'(sym_count), 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_ascii", int'(ascii_char), 8'h2D);
    check("midrst_valid", int'(char_valid), 0);
    check("midrst_err",   int'(decode_err), 0);
    check("midrst_sym",   int'(sym_count),  0);
    check("midrst_busy",  int'(busy),       0);
    repeat (2) tick();
    key   = 1'b0;
    reset = 1'b0;
    gap(3);
    check("post_rst_busy", int'(busy), 0);
    push(1'b0, 8'h54);
    send("-", 15);
    check("T_ascii_held", int'(ascii_char), 8'h54);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
